// File: rtl/rep_pkg.sv
// Shared types and constants for the reply-upload path.
package rep_pkg;

    // Flit control codes carried alongside every flit.
    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // A packet may only open with a head, or be a lone tail (single-flit packet).
    function automatic logic ctrl_ok_first(input logic [1:0] ctrl);
        return (ctrl == CTRL_HEAD) || (ctrl == CTRL_TAIL);
    endfunction

    // Once a packet is open, only body or tail flits may follow.
    function automatic logic ctrl_ok_later(input logic [1:0] ctrl);
        return (ctrl == CTRL_BODY) || (ctrl == CTRL_TAIL);
    endfunction

endpackage

// File: rtl/rep_upload_arbiter_if.sv
// Bundle of upload-engine and reply-FIFO signals around the upload arbiter.
interface rep_upload_arbiter_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned IDX_W   = 1
) ();
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC*FLIT_W-1:0] src_flit;
    logic [NUM_SRC-1:0]        src_v;
    logic [NUM_SRC*2-1:0]      src_ctrl;
    logic [NUM_SRC-1:0]        src_rdy;
    logic                      fifo_rdy;
    logic [FLIT_W-1:0]         flit_out;
    logic                      v_flit_out;
    logic [1:0]                ctrl_out;
    logic [IDX_W-1:0]          grant_idx;
    logic                      busy;
    logic                      err_proto;

    // Arbiter side.
    modport slave (
        input  src_req, src_flit, src_v, src_ctrl, fifo_rdy,
        output src_rdy, flit_out, v_flit_out, ctrl_out, grant_idx, busy, err_proto
    );

    // Engine/FIFO side.
    modport master (
        output src_req, src_flit, src_v, src_ctrl, fifo_rdy,
        input  src_rdy, flit_out, v_flit_out, ctrl_out, grant_idx, busy, err_proto
    );
endinterface

// File: rtl/ring_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ring_rr_pick #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int unsigned cand;

    // Scan NUM_SRC positions starting at ptr; the first hit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = (32'(ptr) + k) % NUM_SRC;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/rep_upload_arbiter.sv
// Packet-locked round-robin arbiter sharing the reply-FIFO write port among upload engines.
module rep_upload_arbiter
    import rep_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned IDX_W   = 1
) (
    input logic                 clk,
    input logic                 rst,
    rep_upload_arbiter_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [FLIT_W-1:0] flit_arr [NUM_SRC];
    logic [1:0]        ctrl_arr [NUM_SRC];
    logic              lock_act;
    logic              accept;
    logic              stray_v;
    logic [IDX_W-1:0]  ptr_after;

    ring_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req (bus.src_req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Unpack the flattened per-source flit and ctrl buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            flit_arr[i] = bus.src_flit[i*FLIT_W +: FLIT_W];
            ctrl_arr[i] = bus.src_ctrl[i*2 +: 2];
        end
    end

    // Output muxes: forward only the owner, and never write during the reset cycle.
    always_comb begin
        lock_act       = (state_q == ARB_LOCK) && !rst;
        accept         = lock_act && bus.src_v[grant_q] && bus.fifo_rdy;
        bus.src_rdy    = '0;
        bus.flit_out   = '0;
        bus.ctrl_out   = CTRL_NONE;
        bus.v_flit_out = 1'b0;
        if (lock_act) begin
            bus.src_rdy[grant_q] = bus.fifo_rdy;
            bus.flit_out         = flit_arr[grant_q];
            bus.ctrl_out         = ctrl_arr[grant_q];
            bus.v_flit_out       = accept;
        end
        bus.grant_idx = grant_q;
        bus.busy      = lock_act;
        bus.err_proto = err_q;
    end

    // Valid from anyone other than the current owner is a protocol error.
    always_comb begin
        stray_v = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.src_v[i] && !((state_q == ARB_LOCK) && (IDX_W'(i) == grant_q))) begin
                stray_v = 1'b1;
            end
        end
        ptr_after = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    end

    // FSM next state, grant/pointer update and protocol checking.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        err_d   = err_q | stray_v;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (first_q ? !ctrl_ok_first(ctrl_arr[grant_q])
                                : !ctrl_ok_later(ctrl_arr[grant_q])) begin
                        err_d = 1'b1;
                    end
                end
                if (accept && (ctrl_arr[grant_q] == CTRL_TAIL)) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_after;
                end else if (!bus.src_req[grant_q]) begin
                    // Owner abandoned its packet: flag it and release the port.
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_after;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_rep_upload_arbiter.sv
// Directed bench for rep_upload_arbiter with two sources.
module tb_rep_upload_arbiter;
    import rep_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rep_upload_arbiter_if #(.NUM_SRC(2), .FLIT_W(16), .IDX_W(1)) bus ();

    rep_upload_arbiter #(
        .NUM_SRC (2),
        .FLIT_W  (16),
        .IDX_W   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        bus.src_req  = '0;
        bus.src_v    = '0;
        bus.src_flit = '0;
        bus.src_ctrl = '0;
        bus.fifo_rdy = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic drive_flit(input int src, input logic [15:0] f, input logic [1:0] c);
        bus.src_v[src]          = 1'b1;
        bus.src_flit[src*16+:16] = f;
        bus.src_ctrl[src*2+:2]   = c;
    endtask

    // Request, wait one cycle for the grant, then push nflit flits (optionally with
    // fifo_rdy toggling 1,0,1,0...) and confirm the port is released after the tail.
    task automatic run_packet(input int src, input int nflit, input bit bp);
        int          k;
        int          cyc;
        int          wr;
        logic        rdy;
        logic [1:0]  c;
        logic [15:0] f;
        bus.src_req[src] = 1'b1;
        #1;
        check_eq("pre_grant_busy", 32'(bus.busy), 32'd0);
        check_eq("pre_grant_rdy", 32'(bus.src_rdy), 32'd0);
        tick;
        check_eq("grant_busy", 32'(bus.busy), 32'd1);
        check_eq("grant_idx", 32'(bus.grant_idx), 32'(src));
        k   = 0;
        wr  = 0;
        cyc = 0;
        while (k < nflit && cyc < 64) begin
            rdy = bp ? (cyc % 2 == 0) : 1'b1;
            if (nflit == 1 || k == nflit - 1) c = CTRL_TAIL;
            else if (k == 0)                 c = CTRL_HEAD;
            else                             c = CTRL_BODY;
            f = 16'((src + 1) * 'h1000 + k);
            bus.fifo_rdy = rdy;
            drive_flit(src, f, c);
            #1;
            check_eq("src_rdy", 32'(bus.src_rdy), 32'(rdy) << src);
            check_eq("v_flit_out", 32'(bus.v_flit_out), 32'(rdy));
            check_eq("busy_in_pkt", 32'(bus.busy), 32'd1);
            if (bus.v_flit_out) wr++;
            if (rdy) begin
                check_eq("flit_out", 32'(bus.flit_out), 32'(f));
                check_eq("ctrl_out", 32'(bus.ctrl_out), 32'(c));
                k++;
            end
            tick;
            cyc++;
        end
        bus.src_req[src] = 1'b0;
        bus.src_v[src]   = 1'b0;
        bus.fifo_rdy     = 1'b1;
        #1;
        check_eq("release_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_v", 32'(bus.v_flit_out), 32'd0);
        check_eq("idle_flit", 32'(bus.flit_out), 32'd0);
        check_eq("write_count", 32'(wr), 32'(nflit));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset;
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rdy", 32'(bus.src_rdy), 32'd0);
        check_eq("rst_v", 32'(bus.v_flit_out), 32'd0);
        check_eq("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
        check_eq("rst_flit", 32'(bus.flit_out), 32'd0);
        check_eq("rst_grant", 32'(bus.grant_idx), 32'd0);
        check_eq("rst_err", 32'(bus.err_proto), 32'd0);

        // Single source, 11-flit packet; pointer moves to 1.
        run_packet(0, 11, 1'b0);

        // Both request with ptr=1: source 1 first, bubble, then source 0.
        bus.src_req = 2'b11;
        run_packet(1, 3, 1'b0);
        run_packet(0, 2, 1'b0);

        // Single-flit packet from source 1; pointer wraps to 0.
        run_packet(1, 1, 1'b0);

        // Both request with ptr=0: source 0 first.
        bus.src_req = 2'b11;
        run_packet(0, 2, 1'b0);
        run_packet(1, 2, 1'b0);

        // Backpressure on a 4-flit packet.
        run_packet(0, 4, 1'b1);
        check_eq("clean_err", 32'(bus.err_proto), 32'd0);

        // Ungranted valid pulse in idle; flag is sticky.
        bus.src_v[1] = 1'b1;
        tick;
        bus.src_v[1] = 1'b0;
        check_eq("err_stray_v", 32'(bus.err_proto), 32'd1);
        tick;
        tick;
        check_eq("err_sticky", 32'(bus.err_proto), 32'd1);
        do_reset;
        #1;
        check_eq("err_cleared", 32'(bus.err_proto), 32'd0);

        // Body as first flit: forwarded, but flagged.
        bus.src_req[0] = 1'b1;
        tick;
        drive_flit(0, 16'hbeef, CTRL_BODY);
        #1;
        check_eq("bad_first_fwd", 32'(bus.v_flit_out), 32'd1);
        tick;
        check_eq("err_bad_first", 32'(bus.err_proto), 32'd1);
        drive_flit(0, 16'hbef0, CTRL_TAIL);
        tick;
        bus.src_req[0] = 1'b0;
        bus.src_v[0]   = 1'b0;
        #1;
        check_eq("bad_first_done", 32'(bus.busy), 32'd0);

        // Request dropped mid-packet: flag, release, advance pointer.
        do_reset;
        bus.src_req[0] = 1'b1;
        tick;
        drive_flit(0, 16'h1111, CTRL_HEAD);
        tick;
        bus.src_req[0] = 1'b0;
        bus.src_v[0]   = 1'b0;
        tick;
        check_eq("drop_busy", 32'(bus.busy), 32'd0);
        check_eq("err_drop", 32'(bus.err_proto), 32'd1);
        bus.src_req = 2'b11;
        tick;
        check_eq("drop_ptr_adv", 32'(bus.grant_idx), 32'd1);
        bus.src_req[0] = 1'b0;

        // Reset after three flits of a source-1 packet.
        drive_flit(1, 16'h2000, CTRL_HEAD);
        tick;
        drive_flit(1, 16'h2001, CTRL_BODY);
        tick;
        drive_flit(1, 16'h2002, CTRL_BODY);
        tick;
        drive_flit(1, 16'h2003, CTRL_BODY);
        rst = 1'b1;
        #1;
        check_eq("rst_cycle_no_write", 32'(bus.v_flit_out), 32'd0);
        tick;
        rst         = 1'b0;
        bus.src_v   = '0;
        bus.src_req = '0;
        #1;
        check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("post_rst_rdy", 32'(bus.src_rdy), 32'd0);
        check_eq("post_rst_v", 32'(bus.v_flit_out), 32'd0);
        check_eq("post_rst_err", 32'(bus.err_proto), 32'd0);
        bus.src_req = 2'b11;
        tick;
        check_eq("post_rst_grant", 32'(bus.grant_idx), 32'd0);
        check_eq("post_rst_lock", 32'(bus.busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
